pc_fetch_unit: RTL

- Instruction-fetch stage of the five-stage MIPS pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC register and selects the next PC from sequential, ID jump, EX branch and exception redirects.
- Runs a request/ready handshake with instruction memory, latching a redirect that arrives while a fetch is outstanding.
- Produces the IF/ID write enable and the IF/ID and ID/EX flush strobes used by the other pipeline stages.

---
 rtl/pc_fetch_unit_pkg.sv | 39 +++
 rtl/pc_fetch_unit_if.sv | 16 +
 rtl/pc_next_sel.sv | 75 +++++++
 rtl/pc_fetch_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// ============================================================================
// pc_fetch_unit_pkg : shared vectors, fetch FSM states and redirect causes
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT       = 2'd1,
    ST_WAIT_REDIR = 2'd2
  } fetch_state_e;

  // Numeric order doubles as priority: lower non-zero value wins.
  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_BR    = 3'd1,
    CAUSE_ILLOP = 3'd2,
    CAUSE_IRQ   = 3'd3,
    CAUSE_JR    = 3'd4,
    CAUSE_J     = 3'd5
  } redirect_cause_e;

  function automatic logic cause_beats(input redirect_cause_e a, input redirect_cause_e b);
    return (a != CAUSE_NONE) && ((b == CAUSE_NONE) || (a < b));
  endfunction

  function automatic logic cause_is_exc(input redirect_cause_e c);
    return (c == CAUSE_ILLOP) || (c == CAUSE_IRQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// pc_fetch_unit_if : instruction-memory request/ready bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if;
  logic [31:0] Imem_addr;
  logic        Imem_req;
  logic        Imem_ready;

  modport master (output Imem_addr, output Imem_req, input Imem_ready);
  modport slave  (input Imem_addr, input Imem_req, output Imem_ready);
endinterface

`default_nettype wire

// File: rtl/pc_next_sel.sv
// ============================================================================
// pc_next_sel : prioritised next-PC mux with jump/jr target formation
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC
) (
  input  logic [31:0]     i_pc,
  input  logic            i_stall,
  input  logic            i_branch_taken,
  input  logic [31:0]     i_branch_target,
  input  logic            i_jump,
  input  logic [25:0]     i_jump_index,
  input  logic            i_jr,
  input  logic [31:0]     i_jr_target,
  input  logic [31:0]     i_pc_plus_4_id,
  input  logic            i_illop,
  input  logic            i_irq,
  output logic [31:0]     o_next_pc,
  output redirect_cause_e o_cause,
  output logic [31:0]     o_epc
);

  logic [31:0]     w_seq_pc;
  logic [31:0]     w_j_target;
  logic [31:0]     w_jr_target;
  logic [31:0]     w_normal_pc;
  redirect_cause_e w_normal_cause;

  assign w_seq_pc    = i_pc + 32'd4;
  assign w_j_target  = {i_pc_plus_4_id[31:28], i_jump_index, 2'b00};
  // jr can only keep supervisor mode if the caller was already there
  assign w_jr_target = {i_pc_plus_4_id[31] & i_jr_target[31], i_jr_target[30:0]};

  // Path taken when no exception or EX branch intervenes; also the IRQ return address.
  always_comb begin
    w_normal_pc    = w_seq_pc;
    w_normal_cause = CAUSE_NONE;
    if (i_jr && !i_stall) begin
      w_normal_pc    = w_jr_target;
      w_normal_cause = CAUSE_JR;
    end else if (i_jump && !i_stall) begin
      w_normal_pc    = w_j_target;
      w_normal_cause = CAUSE_J;
    end else if (i_stall) begin
      w_normal_pc    = i_pc;
    end
  end

  always_comb begin
    o_next_pc = w_normal_pc;
    o_cause   = w_normal_cause;
    o_epc     = 32'd0;
    if (i_branch_taken) begin
      o_next_pc = i_branch_target;
      o_cause   = CAUSE_BR;
    end else if (i_illop) begin
      o_next_pc = ILLOP_VEC;
      o_cause   = CAUSE_ILLOP;
      o_epc     = i_pc_plus_4_id;
    end else if (i_irq && !i_pc[31]) begin
      o_next_pc = IRQ_VEC;
      o_cause   = CAUSE_IRQ;
      o_epc     = w_normal_pc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : IF stage - PC register, imem handshake, redirect strobes
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [31:0] ILLOP_VEC = DEF_ILLOP_VEC
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_fetch_unit_if.master        imem,
  input  logic                   Stall,
  input  logic                   Branch_taken_EX,
  input  logic [31:0]            Branch_target_EX,
  input  logic                   Jump_ID,
  input  logic [25:0]            Jump_index_ID,
  input  logic                   JR_ID,
  input  logic [31:0]            JR_target_ID,
  input  logic [31:0]            PC_plus_4_ID,
  input  logic                   ILLOP_ID,
  input  logic                   IRQ,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus_4,
  output logic                   Fetch_valid,
  output logic                   IFID_write,
  output logic                   Flush_IFID,
  output logic                   Flush_IDEX,
  output logic                   Exc_take,
  output logic [31:0]            EPC
);

  fetch_state_e    r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_pend_target;
  redirect_cause_e r_pend_cause;

  logic [31:0]     w_sel_next;
  redirect_cause_e w_sel_cause;
  logic [31:0]     w_sel_epc;
  logic            w_accept;
  logic            w_exc;
  logic [31:0]     w_target;
  logic [31:0]     w_epc;

  pc_next_sel #(
    .IRQ_VEC   (IRQ_VEC),
    .ILLOP_VEC (ILLOP_VEC)
  ) u_next_sel (
    .i_pc            (r_pc),
    .i_stall         (Stall),
    .i_branch_taken  (Branch_taken_EX),
    .i_branch_target (Branch_target_EX),
    .i_jump          (Jump_ID),
    .i_jump_index    (Jump_index_ID),
    .i_jr            (JR_ID),
    .i_jr_target     (JR_target_ID),
    .i_pc_plus_4_id  (PC_plus_4_ID),
    .i_illop         (ILLOP_ID),
    .i_irq           (IRQ),
    .o_next_pc       (w_sel_next),
    .o_cause         (w_sel_cause),
    .o_epc           (w_sel_epc)
  );

  // With a redirect already pending, only a strictly higher-priority one replaces it.
  assign w_accept = !reset && cause_beats(w_sel_cause,
                      (r_state == ST_WAIT_REDIR) ? r_pend_cause : CAUSE_NONE);
  assign w_exc    = w_accept && cause_is_exc(w_sel_cause);
  assign w_target = ((r_state == ST_WAIT_REDIR) && !w_accept) ? r_pend_target : w_sel_next;

  // An IRQ over a pending jump returns to where that jump was headed.
  assign w_epc = ((w_sel_cause == CAUSE_IRQ) && (r_state == ST_WAIT_REDIR)) ? r_pend_target
                                                                             : w_sel_epc;

  assign Flush_IFID  = w_accept;
  assign Flush_IDEX  = w_accept && ((w_sel_cause == CAUSE_BR) || w_exc);
  assign Exc_take    = w_exc;
  assign EPC         = w_exc ? w_epc : 32'd0;
  assign IFID_write  = !Stall || Flush_IFID;
  assign Fetch_valid = !reset && imem.Imem_ready && (r_state != ST_WAIT_REDIR)
                       && !Flush_IFID && !Stall;

  assign PC             = r_pc;
  assign PC_plus_4      = r_pc + 32'd4;
  assign imem.Imem_addr = r_pc;
  assign imem.Imem_req  = !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_VEC;
      r_pend_target <= 32'd0;
      r_pend_cause  <= CAUSE_NONE;
    end else begin
      unique case (r_state)
        ST_RUN, ST_WAIT: begin
          if (imem.Imem_ready) begin
            r_pc    <= w_target;
            r_state <= ST_RUN;
          end else if (w_accept) begin
            r_pend_target <= w_sel_next;
            r_pend_cause  <= w_sel_cause;
            r_state       <= ST_WAIT_REDIR;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT_REDIR: begin
          if (imem.Imem_ready) begin
            r_pc         <= w_target;
            r_pend_cause <= CAUSE_NONE;
            r_state      <= ST_RUN;
          end else if (w_accept) begin
            r_pend_target <= w_sel_next;
            r_pend_cause  <= w_sel_cause;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

`default_nettype wire
